// File: rtl/reg_loader_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | reg_loader_pkg : shared state encoding and default word width for the       |
// |                  reg_loader serial-to-parallel front end.                   |
// | Revision       : 1.0                                                        |
// +----------------------------------------------------------------------------+
package reg_loader_pkg;

  localparam int c_default_width = 8;

  localparam logic [1:0] c_st_idle   = 2'd0;
  localparam logic [1:0] c_st_data   = 2'd1;
  localparam logic [1:0] c_st_parity = 2'd2;
  localparam logic [1:0] c_st_stop   = 2'd3;

endpackage : reg_loader_pkg
`default_nettype wire

// File: rtl/reg_loader_bit_counter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | bit_counter : loadable up-counter with clear and terminal-count flag at     |
// |               WIDTH-1; holds at terminal count instead of wrapping.         |
// | Revision    : 1.0                                                           |
// +----------------------------------------------------------------------------+
module bit_counter
  import reg_loader_pkg::*;
#(
  parameter int WIDTH = c_default_width
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clr,
  input  logic                     load,
  input  logic [$clog2(WIDTH)-1:0] load_val,
  input  logic                     inc,
  output logic [$clog2(WIDTH)-1:0] count,
  output logic                     tc
);

  localparam int                c_cw     = $clog2(WIDTH);
  localparam logic [c_cw-1:0]   c_tc_val = c_cw'(WIDTH - 1);

  logic [c_cw-1:0] r_count;
  logic            w_tc;

  assign w_tc = (r_count == c_tc_val);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_count <= '0;
    end else if (clr) begin
      r_count <= '0;
    end else if (load) begin
      r_count <= load_val;
    end else if (inc && !w_tc) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign count = r_count;
  assign tc    = w_tc;

endmodule : bit_counter
`default_nettype wire

// File: rtl/reg_loader.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | reg_loader : assembles framed LSB-first serial bits into a WIDTH-bit word,  |
// |              presented as registered d plus one-cycle en / err strobes.     |
// |              Optional even parity bit: define REG_LOADER_PARITY_EN.          |
// | Revision   : 1.0                                                           |
// +----------------------------------------------------------------------------+
module reg_loader
  import reg_loader_pkg::*;
#(
  parameter int WIDTH = c_default_width
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sin,
  input  logic             sin_valid,
  output logic [WIDTH-1:0] d,
  output logic             en,
  output logic             err,
  output logic             busy
);

  localparam int c_cw = $clog2(WIDTH);

  logic [1:0]       r_state;
  logic [1:0]       w_next;
  logic [WIDTH-1:0] r_shift;
  logic [WIDTH-1:0] r_d;
  logic             r_en;
  logic             r_err;

  logic [c_cw-1:0]  w_count;
  logic             w_tc;
  logic             w_cnt_clr;
  logic             w_shift_we;
  logic             w_load;
  logic             w_frame_err;
  logic             w_par_ok;

  bit_counter #(
    .WIDTH (WIDTH)
  ) u_bit_counter (
    .clk      (clk),
    .rst      (rst),
    .clr      (w_cnt_clr),
    .load     (1'b0),
    .load_val ({c_cw{1'b0}}),
    .inc      (w_shift_we),
    .count    (w_count),
    .tc       (w_tc)
  );

`ifdef REG_LOADER_PARITY_EN
  logic r_par;
  logic w_par_we;

  // Even parity: data bits XOR parity bit must come out 0.
  assign w_par_ok = ~((^r_shift) ^ r_par);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_par <= 1'b0;
    end else if (w_par_we) begin
      r_par <= sin;
    end
  end
`else
  assign w_par_ok = 1'b1;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= c_st_idle;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      c_st_idle: begin
        if (sin_valid && !sin) w_next = c_st_data;
      end
      c_st_data: begin
`ifdef REG_LOADER_PARITY_EN
        if (sin_valid && w_tc) w_next = c_st_parity;
`else
        if (sin_valid && w_tc) w_next = c_st_stop;
`endif
      end
`ifdef REG_LOADER_PARITY_EN
      c_st_parity: begin
        if (sin_valid) w_next = c_st_stop;
      end
`endif
      c_st_stop: begin
        if (sin_valid) w_next = c_st_idle;
      end
      default: w_next = c_st_idle;
    endcase
  end

  always_comb begin
    w_cnt_clr   = (r_state == c_st_idle) && sin_valid && !sin;
    w_shift_we  = (r_state == c_st_data) && sin_valid;
`ifdef REG_LOADER_PARITY_EN
    w_par_we    = (r_state == c_st_parity) && sin_valid;
`endif
    w_load      = (r_state == c_st_stop) && sin_valid && sin && w_par_ok;
    w_frame_err = (r_state == c_st_stop) && sin_valid && !(sin && w_par_ok);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_shift <= '0;
      r_d     <= '0;
      r_en    <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_en  <= w_load;
      r_err <= w_frame_err;
      if (w_shift_we) r_shift[w_count] <= sin;
      if (w_load)     r_d <= r_shift;
    end
  end

  assign d    = r_d;
  assign en   = r_en;
  assign err  = r_err;
  assign busy = (r_state != c_st_idle);

endmodule : reg_loader
`default_nettype wire

// File: doc/reg_loader.md
# reg_loader

Serial-to-parallel front end that assembles framed serial bits into a WIDTH-bit word and presents it as a registered data word plus a one-cycle load strobe. It sits directly upstream of the team's enable-register stage: `d` and `en` connect straight to that register's `d` and `en` inputs. Frames use a start bit, LSB-first data, an optional parity bit and a stop bit. Malformed frames are dropped and flagged.

## Interface
- `WIDTH`, default 8: data word width, ≥2.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  asynchronous reset, active-low (asserted at 0).
- `sin`  in  1  serial bit value, sampled only when `sin_valid`=1.
- `sin_valid`  in  1  one-cycle strobe marking `sin` as the next frame bit; gaps of any length are allowed.
- `d`  out  WIDTH  last correctly received word, registered.
- `en`  out  1  one-cycle pulse, high in the cycle `d` first holds a new word.
- `err`  out  1  one-cycle pulse on a framing or parity error.
- `busy`  out  1  high while a frame is in progress (state ≠ IDLE).

## Operation
- States: IDLE, DATA, PARITY (exists only with the macro), STOP.
- IDLE:
  - `sin_valid`=1 with `sin`=0 is a start bit: clear bit count, go to DATA.
  - `sin_valid`=1 with `sin`=1 is line idle: ignored.
- DATA:
  - Each valid bit is written to the shift register at position count, LSB first, then count increments.
  - On the WIDTH-th bit (count = WIDTH-1), go to PARITY if compiled in, otherwise STOP.
  - count is `$clog2(WIDTH)` bits wide and never wraps inside a frame.
- PARITY: one valid bit is captured and checked, then go to STOP.
- STOP: on a valid bit, go to IDLE and:
  - if `sin`=1 and parity is good: `d` ← shift register and `en`=1;
  - otherwise: `err`=1, and `d` holds its previous value.
- `en` and `err` are never high in the same cycle.
- No timeout. A frame stalls indefinitely between bits while `sin_valid`=0.
- `sin_valid`=0 never changes state, count or shift register.

## Timing
- Reset values (asynchronous, while `rst`=0):
  - `d`=0, `en`=0, `err`=0, `busy`=0;
  - state IDLE, count 0, shift register 0.
- Latency: `d`, `en` and `err` update on the clock edge that samples the stop bit. `en`/`err` are high for exactly the following cycle.
- `busy` rises on the edge that samples the start bit. It falls on the edge that samples the stop bit.
- Back-to-back frames:
  - A start bit may arrive in the cycle `en` or `err` is high, because state is already IDLE.
  - No dead cycle is required between frames.
- Reset asserted mid-frame: the partial frame is discarded, and `d` returns to 0 with no `en`. The first valid bit after release is treated as IDLE input.
- Reset deassertion needs no synchronizer inside this block; the integrator guarantees release timing.

## Configuration
- `REG_LOADER_PARITY_EN` defined:
  - the PARITY state exists;
  - a frame carries one even-parity bit after the data bits, where the XOR of the data bits and the parity bit must be 0;
  - a mismatch raises `err` at STOP, even when the stop bit is good.
- Undefined:
  - no PARITY state, and DATA goes directly to STOP;
  - frame length is WIDTH+2 bits.

## Structure
- Shared package `reg_loader_pkg` holds:
  - the state encoding constants (IDLE=0, DATA=1, PARITY=2, STOP=3, 2-bit);
  - the default WIDTH constant.
- Sub-module `bit_counter`: a loadable up-counter with clear, increment and a terminal-count flag at WIDTH-1. Everything else stays in `reg_loader`.

## Test plan
- Frame for 31 without parity, bits 0,1,1,1,1,1,0,0,0,1 with one `sin_valid` per 2 cycles -> after the stop bit, `d`=31, `en` high one cycle, `err` stays 0.
- Frame for 127 with a stop bit of 0 after a previous good 31 -> `err` pulses once, `d` stays 31, no `en`.
- Two back-to-back frames, 127 then 12, with the second start bit in the `en` cycle of the first -> two `en` pulses, `d`=127 then 12.
- Reset asserted after 4 data bits of 100, released, then a full frame for 100 -> `d`=0 during reset, then `d`=100 with one `en` and no `err`.
- Idle 1s with `sin_valid`, plus 20-cycle gaps between data bits of a frame for 5 -> `busy` is 0 until the start bit, then `d`=5 and `en` pulses.
- With `REG_LOADER_PARITY_EN`: 31 with parity bit 1 -> `en`, `d`=31; 31 with parity bit 0 -> `err`, `d` unchanged.
